// File: rtl/muldiv_pkg.sv
// Shared op-bit indices and FSM encoding for the HI/LO multiply/divide unit.
// The ID decoder uses the same op constants to build md_op_in.
package muldiv_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MFHI  = 4;
  localparam int OP_MFLO  = 5;
  localparam int OP_MTHI  = 6;
  localparam int OP_MTLO  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on unsigned operands, one quotient bit per step.
// done pulses during the final step; results are stable from the next cycle.
module div_core #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  logic [CNT_W-1:0] count;
  logic [63:0]      rq;
  logic [31:0]      dvs;
  logic [32:0]      trial;

  // Shifted partial remainder minus divisor; bit 32 set means it did not fit.
  assign trial = rq[63:31] - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (start) count <= '0;
    else if (step)  count <= count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rq  <= {32'd0, dividend};
      dvs <= divisor;
    end else if (step) begin
      rq <= trial[32] ? {rq[62:0], 1'b0} : {trial[31:0], rq[30:0], 1'b1};
    end
  end

  assign done      = step && (count == CNT_W'(DIV_ITER - 1));
  assign quotient  = rq[31:0];
  assign remainder = rq[63:32];

endmodule

// File: rtl/muldiv_sched.sv
// EXE-stage sequencer for the shared multiply/divide unit: owns HI/LO,
// stalls EXE via md_ready_out, and drops in-flight work on flush.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_valid_in,
  input  logic [7:0]  md_op_in,
  input  logic [31:0] md_src1_in,
  input  logic [31:0] md_src2_in,
  input  logic        md_flush_in,
  output logic        md_ready_out,
  output logic        md_busy_out,
  output logic [31:0] md_rdata_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_t state, state_nx;

  logic               accept, take_mul, take_div, op_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic               q_neg, r_neg, dz;
  logic               div_step, div_done;
  logic [31:0]        dvd_abs, dvs_abs, quot, rem;
  logic               hi_we, lo_we;
  logic [31:0]        hi_d, lo_d;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign accept    = (state == ST_IDLE) && md_valid_in && !md_flush_in && $onehot(md_op_in);
  assign take_mul  = accept && (md_op_in[OP_MULT] || md_op_in[OP_MULTU]);
  assign take_div  = accept && (md_op_in[OP_DIV] || md_op_in[OP_DIVU]);
  assign op_signed = md_op_in[OP_MULT] || md_op_in[OP_DIV];
  assign dvd_abs   = neg_if(md_src1_in, op_signed && md_src1_in[31]);
  assign dvs_abs   = neg_if(md_src2_in, op_signed && md_src2_in[31]);
  assign div_step  = (state == ST_DIV) && !md_flush_in;

  always_ff @(posedge clk) begin
    if (take_mul) begin
      mul_a <= {op_signed && md_src1_in[31], md_src1_in};
      mul_b <= {op_signed && md_src2_in[31], md_src2_in};
    end
    if (take_div) begin
      q_neg <= op_signed && (md_src1_in[31] ^ md_src2_in[31]);
      r_neg <= op_signed && md_src1_in[31];
      dz    <= (md_src2_in == 32'd0);
    end
  end

  assign prod = 64'(mul_a) * 64'(mul_b);

  div_core #(.DIV_ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (take_div),
    .step      (div_step),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .done      (div_done),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    md_ready_out = 1'b0;
    md_rdata_out = 32'd0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    hi_d         = md_src1_in;
    lo_d         = md_src1_in;
    if (md_flush_in) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take_mul)      state_nx = ST_MUL;
          else if (take_div) state_nx = ST_DIV;
          else if (accept) begin
            md_ready_out = 1'b1;
            if (md_op_in[OP_MFHI]) md_rdata_out = hi_out;
            if (md_op_in[OP_MFLO]) md_rdata_out = lo_out;
            hi_we = md_op_in[OP_MTHI];
            lo_we = md_op_in[OP_MTLO];
          end
        end
        ST_MUL: begin
          md_ready_out = 1'b1;
          hi_we        = 1'b1;
          lo_we        = 1'b1;
          hi_d         = prod[63:32];
          lo_d         = prod[31:0];
          state_nx     = ST_IDLE;
        end
        ST_DIV: begin
          if (div_done) state_nx = ST_FIX;
        end
        ST_FIX: begin
          // Divide by zero leaves the remainder equal to the dividend, so only LO needs forcing.
          md_ready_out = 1'b1;
          hi_we        = 1'b1;
          lo_we        = 1'b1;
          hi_d         = neg_if(rem, r_neg);
          lo_d         = dz ? 32'hFFFF_FFFF : neg_if(quot, q_neg);
          state_nx     = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else begin
      if (hi_we) hi_out <= hi_d;
      if (lo_we) lo_out <= lo_d;
    end
  end

  assign md_busy_out = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: multiply/divide results, handshake timing,
// MF/MT access, flush and asynchronous reset behaviour.
module tb_muldiv_sched;

  localparam logic [7:0] MULT  = 8'h01;
  localparam logic [7:0] MULTU = 8'h02;
  localparam logic [7:0] DIV   = 8'h04;
  localparam logic [7:0] DIVU  = 8'h08;
  localparam logic [7:0] MFHI  = 8'h10;
  localparam logic [7:0] MFLO  = 8'h20;
  localparam logic [7:0] MTHI  = 8'h40;
  localparam logic [7:0] MTLO  = 8'h80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_valid = 1'b0;
  logic [7:0]  md_op = 8'h00;
  logic [31:0] md_src1 = 32'd0;
  logic [31:0] md_src2 = 32'd0;
  logic        md_flush = 1'b0;
  logic        md_ready, md_busy;
  logic [31:0] md_rdata, hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_sched #(.DIV_ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .md_valid_in  (md_valid),
    .md_op_in     (md_op),
    .md_src1_in   (md_src1),
    .md_src2_in   (md_src2),
    .md_flush_in  (md_flush),
    .md_ready_out (md_ready),
    .md_busy_out  (md_busy),
    .md_rdata_out (md_rdata),
    .hi_out       (hi),
    .lo_out       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues a mul/div at the start of a cycle, waits for ready, then checks HI/LO.
  // Returns in the cycle after ready, after its negedge, with valid dropped.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_rdy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = -1;
    logic busy1 = 1'b0;
    logic busy_r = 1'b0;
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = op; md_src1 = a; md_src2 = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 1) busy1 = md_busy;
      if (md_ready) begin
        cyc = i;
        busy_r = md_busy;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_rdy_cycle"}, 32'(cyc), 32'(exp_rdy));
    chk({tag, "_busy_c1"}, {31'd0, busy1}, 32'd1);
    chk({tag, "_busy_rdy"}, {31'd0, busy_r}, 32'd1);
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 8'h00;
    @(negedge clk);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_idle"}, {31'd0, md_busy}, 32'd0);
  endtask

  // Single-cycle MF/MT/no-op access driven in the current cycle.
  task automatic run_mx(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic flush, input logic exp_rdy, input logic [31:0] exp_rdata,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md_valid = 1'b1; md_op = op; md_src1 = a; md_flush = flush;
    #1;
    chk({tag, "_ready"}, {31'd0, md_ready}, {31'd0, exp_rdy});
    chk({tag, "_rdata"}, md_rdata, exp_rdata);
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 8'h00; md_flush = 1'b0;
    @(negedge clk);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    logic any_rdy;

    #3;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ready", {31'd0, md_ready}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_rdata", md_rdata, 32'd0);
    #19 rst = 1'b0;

    run_op("mult", MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mx("mfhi_b2b", MFHI, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_mx("mflo_b2b", MFLO, 32'd0, 1'b0, 1'b1, 32'd14, 32'd2, 32'd14);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("div_zero", DIV, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF);

    run_mx("bad_op", 8'h30, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_mx("mtlo", MTLO, 32'h0000_1234, 1'b0, 1'b1, 32'd0, 32'd5, 32'h0000_1234);

    // Flush in cycle 10 of DIV 9/3 must abandon the divide without touching HI/LO.
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = DIV; md_src1 = 32'd9; md_src2 = 32'd3;
    any_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_rdy |= md_ready;
      @(posedge clk); #1;
    end
    md_flush = 1'b1;
    @(negedge clk);
    any_rdy |= md_ready;
    chk("flush_no_ready", {31'd0, any_rdy}, 32'd0);
    @(posedge clk); #1;
    md_flush = 1'b0; md_valid = 1'b0; md_op = 8'h00;
    @(negedge clk);
    chk("flush_idle", {31'd0, md_busy}, 32'd0);
    run_mx("flush_mflo", MFLO, 32'd0, 1'b0, 1'b1, 32'h0000_1234, 32'd5, 32'h0000_1234);

    // Asynchronous reset in cycle 20 of a divide.
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = DIVU; md_src1 = 32'd100; md_src2 = 32'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, md_busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    md_valid = 1'b0; md_op = 8'h00;
    @(negedge clk);
    rst = 1'b0;

    run_mx("mthi_flush", MTHI, 32'd5, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    run_mx("mthi", MTHI, 32'd5, 1'b0, 1'b1, 32'd0, 32'd5, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the shared HI/LO multiply/divide resource in the EXE stage. It accepts one `mult_div_op` request at a time from the pipeline, runs a 2-cycle multiply or a 34-cycle iterative divide, and owns the architectural HI/LO registers. It stalls the EXE stage through a retire handshake, services MFHI/MFLO/MTHI/MTLO in one cycle, and aborts in-flight work on an exception flush.

## Interface
Parameters:
- `DIV_ITER`, 32: divider iterations; the counter width is derived from it.

Ports:
- `clk`  in  1  — the single clock; all state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `md_valid_in`  in  1  — EXE holds a valid muldiv op; held until retired.
- `md_op_in`  in  8  — one-hot op: bit0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `md_src1_in`  in  32  — rs value.
- `md_src2_in`  in  32  — rt value.
- `md_flush_in`  in  1  — exception flush; cancels the current op.
- `md_ready_out`  out  1  — the op retires this cycle; EXE may advance.
- `md_busy_out`  out  1  — state is not IDLE.
- `md_rdata_out`  out  32  — HI for MFHI, LO for MFLO; 0 otherwise.
- `hi_out`, `lo_out`  out  32 each  — architectural HI and LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **Reset:** state=IDLE, HI=LO=0, count=0. All outputs are 0.
- **IDLE with valid and no flush:**
  - MF*/MT*: `md_ready_out`=1 combinationally. MFHI/MFLO drive `md_rdata_out`. MTHI/MTLO write src1 at the edge. State stays IDLE.
  - MULT/MULTU: capture operands, go to MUL, ready=0.
  - DIV/DIVU: capture |src1| and |src2| (raw values for DIVU), record sign flags, clear count, go to DIV, ready=0.
- **MUL:**
  - ready=1.
  - 64-bit product of the 33-bit sign- or zero-extended operands is written as {HI,LO} at the edge.
  - Next state is IDLE.
- **DIV:**
  - One restoring step per cycle: 64-bit remainder/quotient shift register, 33-bit trial subtract.
  - count increments each step. After `DIV_ITER` steps, go to FIX.
  - ready=0 throughout.
- **FIX:**
  - ready=1.
  - For DIV: LO = quotient, negated if the sign flags differ. HI = remainder, negated if the dividend was negative.
  - Next state is IDLE.
- **Divide by zero** (src2==0 at capture): takes the same 34 cycles. Result is LO=32'hFFFFFFFF and HI=src1 unmodified, for both DIV and DIVU.
- **Overflow:** DIV 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0. This is the natural result of the algorithm.
- **Flush:**
  - Has priority over everything except reset.
  - In any state, the next state is IDLE. HI/LO are not written and ready=0 that cycle.
  - A flush in IDLE suppresses an MT* write.
- `md_valid_in` is not sampled outside IDLE. Operands are taken only from the capture registers.
- `md_op_in` with zero or multiple bits set is treated as no op: ready=0, nothing is written.

## Timing
- **MF/MT:** 1 cycle. ready is combinational from the inputs in IDLE.
- **MULT:** accept in cycle 0 (IDLE), ready in cycle 1 (MUL), result visible on `hi_out`/`lo_out` in cycle 2.
- **DIV:**
  - Accept in cycle 0; DIV occupies cycles 1–32; FIX with ready=1 in cycle 33.
  - HI/LO are updated in cycle 34.
- **Back-to-back:** MFHI may be accepted in the cycle after ready. It then returns the new HI with no bypass.
- **Reset:** asserting `rst` mid-divide returns state to IDLE and clears HI/LO asynchronously.

## Structure
- `muldiv_pkg` holds the one-hot op bit index constants and the 2-bit state encoding. The ID decoder shares the op constants.
- Sub-module `div_core`: iterative restoring divider.
  - Inputs: start, unsigned operands.
  - Outputs: done, quotient, remainder.
  - Internal: 64-bit shift register and count.
- `muldiv_sched` holds the FSM, sign handling, the multiply, HI/LO and the handshake.

## Test plan
- **Signed multiply:** MULT src1=32'hFFFFFFFD (-3), src2=7 → ready exactly at cycle 1; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- **Unsigned multiply:** MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001.
- **Signed divide:**
  - DIV -7/2 → ready only at cycle 33, busy cycles 1–33; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - DIVU 100/7 → LO=14, HI=2.
- **Edge-case divides:**
  - DIV 32'h80000000/32'hFFFFFFFF → LO=32'h80000000, HI=0.
  - DIV 5/0 → LO=32'hFFFFFFFF, HI=5.
- **Flush mid-divide:** MTLO 32'h1234 then DIV 9/3, flush at cycle 10 → IDLE at cycle 11, no ready; then MFLO → rdata=32'h1234 with ready in 1 cycle.
- **Async reset mid-divide:** assert `rst` at cycle 20 of a DIV → immediate IDLE, HI=LO=0. Flush in IDLE with MTHI 5 → HI unchanged.
